argmax_stream: RTL and testbench

ARGMAX_STREAM -- requirements
Module: argmax_stream

---
 rtl/argmax_stream.sv | 135 +++++++++++++
 tb/tb_argmax_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over one frame of signed class scores.
// A frame is NUM_CLASS beats, or fewer if in_last arrives early. The winning
// index/value is held for the consumer and persists after hand-off, so a
// display downstream keeps showing the last result.
module argmax_stream #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  max_index,
    output logic [DATA_W-1:0] max_value,
    output logic              frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASS - 1);
    localparam logic [IDX_W-1:0] NO_RESULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic signed [DATA_W-1:0]  r_run_max, w_run_max_nxt;
    logic [IDX_W-1:0]          r_run_idx, w_run_idx_nxt;
    logic [IDX_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      r_in_ready, w_in_ready_nxt;
    logic                      r_out_valid, w_out_valid_nxt;
    logic [IDX_W-1:0]          r_max_index, w_max_index_nxt;
    logic [DATA_W-1:0]         r_max_value, w_max_value_nxt;
    logic                      r_frame_err, w_frame_err_nxt;

    logic                      w_accept;
    logic [IDX_W-1:0]          w_beat_idx;
    logic                      w_last_beat;
    logic                      w_take;
    logic signed [DATA_W-1:0]  w_cand_max;
    logic [IDX_W-1:0]          w_cand_idx;
    logic                      w_frame_end;

    // Beat position and candidate running max including the current beat.
    always_comb begin
        w_accept    = in_valid && r_in_ready;
        w_beat_idx  = (r_state == ST_IDLE) ? '0 : r_cnt;
        w_last_beat = (w_beat_idx == LAST_IDX);
        // First beat always seeds; later beats win only on strictly greater.
        w_take      = (r_state == ST_IDLE) || ($signed(in_data) > r_run_max);
        w_cand_max  = w_take ? $signed(in_data) : r_run_max;
        w_cand_idx  = w_take ? w_beat_idx : r_run_idx;
        w_frame_end = w_accept && (in_last || w_last_beat);
    end

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt     = r_state;
        w_run_max_nxt   = r_run_max;
        w_run_idx_nxt   = r_run_idx;
        w_cnt_nxt       = r_cnt;
        w_max_index_nxt = r_max_index;
        w_max_value_nxt = r_max_value;
        w_frame_err_nxt = r_frame_err;

        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    w_run_max_nxt = w_cand_max;
                    w_run_idx_nxt = w_cand_idx;
                    if (w_frame_end) begin
                        w_state_nxt     = ST_HOLD;
                        w_cnt_nxt       = '0;
                        w_max_index_nxt = w_cand_idx;
                        w_max_value_nxt = DATA_W'(w_cand_max);
                        // Well-formed only when in_last coincides with the final slot.
                        w_frame_err_nxt = !(in_last && w_last_beat);
                    end else begin
                        w_state_nxt = ST_ACCUM;
                        w_cnt_nxt   = w_beat_idx + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt != ST_HOLD);
        w_out_valid_nxt = (w_state_nxt == ST_HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_max_index <= NO_RESULT;
            r_max_value <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_max   <= w_run_max_nxt;
            r_run_idx   <= w_run_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_max_index <= w_max_index_nxt;
            r_max_value <= w_max_value_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign max_index = r_max_index;
    assign max_value = r_max_value;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_argmax_stream.sv
// Self-checking bench for argmax_stream: directed frames plus randomized
// back-to-back frames with gaps, checked against a queue-based argmax model.
module tb_argmax_stream;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 10;
    localparam int unsigned IW = 4;

    logic          sys_clk;
    logic          sys_rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] max_index;
    logic [DW-1:0] max_value;
    logic          frame_err;

    argmax_stream #(.DATA_W(DW), .NUM_CLASS(NC), .IDX_W(IW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_index (max_index),
        .max_value (max_value),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    logic signed [DW-1:0] q_sc[$];
    bit                   q_last;
    logic [IW-1:0]        e_idx;
    logic [DW-1:0]        e_val;
    logic                 e_err;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: largest score wins, earliest position breaks ties.
    task automatic model();
        logic signed [DW-1:0] best;
        best = q_sc[0];
        foreach (q_sc[i]) if (q_sc[i] > best) best = q_sc[i];
        e_idx = '0;
        for (int i = q_sc.size() - 1; i >= 0; i--) if (q_sc[i] == best) e_idx = IW'(i);
        e_val = best;
        e_err = !(q_last && (q_sc.size() == NC));
    endtask

    task automatic send_frame(input bit gaps);
        int n;
        foreach (q_sc[i]) begin
            if (gaps) begin
                for (int g = 0; g < 4 && ($urandom_range(1, 0) == 1); g++) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    in_last  = 1'($urandom_range(1, 0));
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = q_sc[i];
            in_last  = q_last && (i == q_sc.size() - 1);
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            check("beat_ready", 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Result must be present exactly one cycle after the frame-ending accept.
    task automatic check_result(input string tag);
        model();
        check({tag, "_ovalid"}, 64'(out_valid), 64'd1);
        check({tag, "_idx"},    64'(max_index), 64'(e_idx));
        check({tag, "_val"},    64'(max_value), 64'(e_val));
        check({tag, "_err"},    64'(frame_err), 64'(e_err));
        check({tag, "_irdy"},   64'(in_ready),  64'd0);
    endtask

    task automatic release_result(input string tag, input int delay);
        for (int d = 0; d < delay; d++) begin
            tick();
            check({tag, "_hold"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"},    64'(out_valid), 64'd0);
        check({tag, "_persist"}, 64'(max_index), 64'(e_idx));
        check({tag, "_rdy"},     64'(in_ready),  64'd1);
    endtask

    initial begin
        sys_clk   = 1'b0;
        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_irdy",  64'(in_ready),  64'd0);
        check("rst_ovld",  64'(out_valid), 64'd0);
        check("rst_idx",   64'(max_index), 64'hF);
        check("rst_val",   64'(max_value), 64'd0);
        check("rst_err",   64'(frame_err), 64'd0);
        sys_rst = 1'b0;
        tick();
        check("post_rst_irdy", 64'(in_ready), 64'd1);
        check("post_rst_ovld", 64'(out_valid), 64'd0);

        // Basic frame, ties on 7 keep the lower index.
        q_sc = '{3, -1, 7, 2, 7, 0, 5, 1, 4, -20};
        q_last = 1'b1;
        send_frame(1'b0);
        check_result("basic");
        check("basic_const_idx", 64'(max_index), 64'd2);
        check("basic_const_val", 64'(max_value), 64'd7);
        check("basic_const_err", 64'(frame_err), 64'd0);
        release_result("basic", 0);

        // Backpressure: beat offered while holding must not be consumed.
        send_frame(1'b0);
        check_result("bp");
        in_valid = 1'b1;
        in_data  = 32'd1000;
        in_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_irdy", 64'(in_ready),  64'd0);
            check("bp_ovld", 64'(out_valid), 64'd1);
            check("bp_idx",  64'(max_index), 64'd2);
            check("bp_val",  64'(max_value), 64'd7);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_rel_ovld", 64'(out_valid), 64'd0);
        check("bp_rel_irdy", 64'(in_ready),  64'd1);
        q_sc = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4};
        send_frame(1'b0);
        check_result("bp_next");
        check("bp_next_const_idx", 64'(max_index), 64'd9);
        release_result("bp_next", 1);

        // Most negative value everywhere.
        q_sc = {};
        for (int i = 0; i < NC; i++) q_sc.push_back(32'sh8000_0000);
        send_frame(1'b0);
        check_result("minval");
        check("minval_const_idx", 64'(max_index), 64'd0);
        check("minval_const_val", 64'(max_value), 64'h8000_0000);
        release_result("minval", 0);

        // Early in_last.
        q_sc = '{1, 5, 2, 3};
        send_frame(1'b0);
        check_result("short");
        check("short_const_idx", 64'(max_index), 64'd1);
        check("short_const_err", 64'(frame_err), 64'd1);
        release_result("short", 0);

        // Missing in_last: frame closes at the final slot anyway.
        q_sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        q_last = 1'b0;
        send_frame(1'b0);
        check_result("nolast");
        check("nolast_const_err", 64'(frame_err), 64'd1);
        release_result("nolast", 0);

        // Reset mid-frame discards the partial frame.
        q_sc = '{50, 60, 70, 80, 90, 100};
        q_last = 1'b0;
        send_frame(1'b0);
        check("midrst_pre_ovld", 64'(out_valid), 64'd0);
        sys_rst = 1'b1;
        tick();
        check("midrst_idx",  64'(max_index), 64'hF);
        check("midrst_ovld", 64'(out_valid), 64'd0);
        check("midrst_irdy", 64'(in_ready),  64'd0);
        sys_rst = 1'b0;
        tick();
        check("midrst_post_irdy", 64'(in_ready), 64'd1);
        q_sc = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 10};
        q_last = 1'b1;
        send_frame(1'b0);
        check_result("fresh");
        check("fresh_const_idx", 64'(max_index), 64'd9);
        check("fresh_const_err", 64'(frame_err), 64'd0);
        release_result("fresh", 0);

        // Randomized frames with input gaps and random consumer delay.
        for (int f = 0; f < 30; f++) begin
            int len;
            len = int'($urandom_range(NC, 2));
            q_sc = {};
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(5, 0))
                    0:       q_sc.push_back(32'sh8000_0000);
                    1:       q_sc.push_back(32'sh7FFF_FFFF);
                    2:       q_sc.push_back(32'($signed($urandom_range(3, 0)) - 1));
                    default: q_sc.push_back($urandom);
                endcase
            end
            q_last = (len == NC) ? bit'($urandom_range(1, 0)) : 1'b1;
            send_frame(1'b1);
            check_result("rand");
            release_result("rand", int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
